// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fixed up at the end.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [4:0]      rd_in,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            result_valid,
   output logic            stall,
   output logic            busy
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
   localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rdl_q, rdl_d, rdo_q, rdo_d;
   logic [XLEN-1:0]   res_q, res_d, opb_q, opb_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              aneg_q, aneg_d, bneg_q, bneg_d, busy_q;

   logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, accept, ge;
   logic [XLEN-1:0]   a_mag, b_mag, spec_res, trial, quot, rem, fix_res;
   logic [XLEN:0]     msum, rsh;
   logic [2*XLEN-1:0] mul_next, div_next, prod;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (op)
         3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
         3'b010:                         a_sgn = 1'b1;
         default: ;
      endcase
   end

   assign a_neg    = a_sgn & src_a[XLEN-1];
   assign b_neg    = b_sgn & src_b[XLEN-1];
   assign a_mag    = a_neg ? -src_a : src_a;
   assign b_mag    = b_neg ? -src_b : src_b;
   assign div_zero = op[2] && (src_b == '0);
   assign div_ovf  = op[2] && !op[0] && (src_a == SMIN) && (&src_b);
   assign spec_res = div_zero ? (op[1] ? src_a : '1) : (op[1] ? '0 : SMIN);
   assign accept   = (state_q == S_IDLE) && start && !kill;

   // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
   assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {msum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

   // Divide: acc = {remainder, quotient}; shift left and try subtracting the divisor.
   assign rsh      = acc_q[2*XLEN-1:XLEN-1];
   assign ge       = rsh >= {1'b0, opb_q};
   assign trial    = rsh[XLEN-1:0] - opb_q;
   assign div_next = ge ? {trial, acc_q[XLEN-2:0], 1'b1} : {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

   assign prod = (aneg_q ^ bneg_q) ? -acc_q : acc_q;
   assign quot = (aneg_q ^ bneg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem  = aneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      case (op_q)
         3'b000:         fix_res = prod[XLEN-1:0];
         3'b100, 3'b101: fix_res = quot;
         3'b110, 3'b111: fix_res = rem;
         default:        fix_res = prod[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rdl_d   = rdl_q;
      rdo_d   = rdo_q;
      res_d   = res_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      aneg_d  = aneg_q;
      bneg_d  = bneg_q;
      case (state_q)
         S_IDLE: if (accept) begin
            op_d   = op;
            rdl_d  = rd_in;
            aneg_d = a_neg;
            bneg_d = b_neg;
            cnt_d  = '0;
            acc_d  = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
            opb_d  = op[2] ? b_mag : a_mag;
            if (div_zero || div_ovf) begin
               res_d   = spec_res;
               rdo_d   = rd_in;
               state_d = S_DONE;
            end else begin
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            res_d   = fix_res;
            rdo_d   = rdl_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A flush drops the op without touching the presented result.
      if (kill) begin
         state_d = S_IDLE;
         res_d   = res_q;
         rdo_d   = rdo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         rdl_q   <= '0;
         rdo_q   <= '0;
         res_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         aneg_q  <= 1'b0;
         bneg_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rdl_q   <= rdl_d;
         rdo_q   <= rdo_d;
         res_q   <= res_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         aneg_q  <= aneg_d;
         bneg_q  <= bneg_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign result       = res_q;
   assign rd_out       = rdo_q;
   assign result_valid = (state_q == S_DONE);
   assign busy         = busy_q;
   assign stall        = accept || (state_q == S_CALC) || (state_q == S_FIX);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results queued on issue, checked when result_valid pulses.
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  op;
   logic [31:0] src_a, src_b, result;
   logic [4:0]  rd_in, rd_out;
   logic        result_valid, stall, busy;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                          DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
      .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
      .result(result), .rd_out(rd_out), .result_valid(result_valid),
      .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every result pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && result_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", {63'd0, result_valid}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", {32'd0, result}, {32'd0, e.res});
            check("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
         end
      end
   end

   // Issue one op in the current cycle and follow it until its pulse; intr_k>0 also
   // raises a second start in cycle T+intr_k, which must be ignored.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int lat, input int intr_k);
      int st, vat;
      st = 0;
      vat = 0;
      start = 1'b1; op = o; src_a = a; src_b = b; rd_in = rd;
      sb.push_back('{exp_res, rd});
      @(negedge clk);
      if (stall) st++;
      tick();
      for (int k = 1; k <= 40 && vat == 0; k++) begin
         if (k == intr_k) begin
            start = 1'b1; op = MUL; src_a = 32'd3; src_b = 32'd3; rd_in = 5'd31;
         end else begin
            start = 1'b0; src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
         end
         @(negedge clk);
         if (stall) st++;
         if (result_valid) vat = k;
         if (k == 1) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
         tick();
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(vat), 64'(lat));
      check({tag, "_stall_cycles"}, 64'(st), 64'(lat));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; src_a = '0; src_b = '0; rd_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_result", {32'd0, result}, 64'd0);
      check("reset_rd", {59'd0, rd_out}, 64'd0);
      check("reset_valid", {63'd0, result_valid}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_stall", {63'd0, stall}, 64'd0);
      tick();

      // Multiplies, issued back to back.
      run_op("mul_7_m3",   MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34, 0);
      run_op("mulhu_m1",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34, 0);
      run_op("mulh_m1",    MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 34, 0);
      run_op("mulhsu_m1",  MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34, 0);
      run_op("mul_m1",     MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001, 34, 0);
      run_op("mulh_min",   MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34, 0);
      run_op("mulhsu_min", MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 34, 0);

      // Divides.
      run_op("div_m7_2",   DIV,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 34, 0);
      run_op("rem_m7_2",   REM,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 34, 0);
      run_op("divu_100_7", DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       34, 0);
      run_op("remu_100_7", REMU,   32'd100,      32'd7,        5'd11, 32'd2,        34, 0);
      run_op("div_7_m2",   DIV,    32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 34, 0);
      run_op("rem_7_m2",   REM,    32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        34, 0);
      run_op("div_min_2",  DIV,    32'h80000000, 32'd2,        5'd14, 32'hC0000000, 34, 0);
      run_op("divu_max_1", DIVU,   32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF, 34, 0);

      // Special cases complete in the cycle after acceptance.
      run_op("divu_5_0",   DIVU,   32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1, 0);
      run_op("rem_5_0",    REM,    32'd5,        32'd0,        5'd17, 32'd5,        1, 0);
      run_op("div_5_0",    DIV,    32'd5,        32'd0,        5'd18, 32'hFFFFFFFF, 1, 0);
      run_op("div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1, 0);
      run_op("rem_ovf",    REM,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1, 0);

      // Start while busy is ignored; only the first op completes.
      run_op("busy_start", DIVU,   32'd1000,     32'd9,        5'd21, 32'd111,      34, 5);
      repeat (40) tick();

      // Kill at T+10 mid-CALC, then a fresh op at T+11 completes at T+45.
      start = 1'b1; op = MUL; src_a = 32'd9; src_b = 32'd9; rd_in = 5'd22;
      tick();
      start = 1'b0;
      repeat (9) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      #1;
      check("kill_busy", {63'd0, busy}, 64'd0);
      check("kill_stall", {63'd0, stall}, 64'd0);
      check("kill_valid", {63'd0, result_valid}, 64'd0);
      run_op("after_kill", MULHU,  32'h00010000, 32'h00030000, 5'd23, 32'd3,        34, 0);

      // start and kill together: nothing accepted.
      start = 1'b1; kill = 1'b1; op = DIVU; src_a = 32'd50; src_b = 32'd5; rd_in = 5'd24;
      #1;
      check("startkill_stall", {63'd0, stall}, 64'd0);
      tick();
      start = 1'b0; kill = 1'b0;
      #1;
      check("startkill_busy", {63'd0, busy}, 64'd0);
      repeat (40) tick();

      // Reset at T+20 mid-CALC clears everything.
      start = 1'b1; op = DIV; src_a = 32'd77; src_b = 32'd7; rd_in = 5'd25;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_rd", {59'd0, rd_out}, 64'd0);
      check("rst_valid", {63'd0, result_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      repeat (40) tick();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
